// File: rtl/udp_tx_framer.sv
// Builds one Ethernet/IPv4/UDP frame per start request and streams it as
// 36-bit {occ, eof, sof, data} words into the GEMAC TX FIFO interface.
module udp_tx_framer #(
  parameter logic [47:0] DST_MAC  = 48'h0023_DFFF_3311,
  parameter logic [47:0] SRC_MAC  = 48'h0037_FFFF_3737,
  parameter logic [31:0] SRC_IP   = 32'hA9FE_4D01,
  parameter logic [31:0] DST_IP   = 32'hA9FE_4D9D,
  parameter logic [15:0] SRC_PORT = 16'h1234,
  parameter logic [7:0]  TTL      = 8'h40,
  parameter int unsigned MAX_LEN  = 1472
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] payload_len,
  input  logic [15:0] dst_port,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] pkt_count,
  output logic [35:0] tx_f36_data,
  output logic        tx_f36_src_rdy,
  input  logic        tx_f36_dst_rdy
);

  localparam logic [10:0] MaxLen = 11'(MAX_LEN);

  typedef enum logic [1:0] {StIdle, StCsum, StFold, StSend} state_e;
  state_e state_q, state_d;

  logic [10:0] len_q;
  logic [15:0] port_q, ip_id_q, csum_q, pkt_count_q;
  logic [19:0] sum_q;
  logic [3:0]  hw_idx_q;
  logic [8:0]  word_idx_q;
  logic [35:0] data_q;
  logic        src_rdy_q, done_q, err_q;

  logic        len_ok, accept, xfer, eof_xfer;
  logic [15:0] total_len, udp_len, hw;
  logic [10:0] frame_len;
  logic [8:0]  last_word;
  logic [16:0] fold1;
  logic [15:0] fold2;
  logic [335:0] hdr;
  logic [7:0]  hdr_b [42];
  logic [10:0] lane_idx [4];
  logic [31:0] word_data;
  logic        word_sof, word_eof;
  logic [35:0] next_word;

  assign len_ok    = (payload_len != 11'd0) && (payload_len <= MaxLen);
  assign accept    = start && len_ok && (state_q == StIdle);
  assign xfer      = src_rdy_q && tx_f36_dst_rdy;
  assign eof_xfer  = xfer && data_q[33];

  assign total_len = 16'd28 + {5'b0, len_q};
  assign udp_len   = 16'd8 + {5'b0, len_q};
  assign frame_len = 11'd42 + len_q;
  assign last_word = 9'((frame_len - 11'd1) >> 2);

  // End-around carry can ripple twice, so fold the sum in two steps.
  assign fold1 = {1'b0, sum_q[15:0]} + {13'b0, sum_q[19:16]};
  assign fold2 = fold1[15:0] + {15'b0, fold1[16]};

  always_comb begin
    unique case (hw_idx_q)
      4'd0:    hw = 16'h4500;
      4'd1:    hw = total_len;
      4'd2:    hw = ip_id_q;
      4'd4:    hw = {TTL, 8'h11};
      4'd6:    hw = SRC_IP[31:16];
      4'd7:    hw = SRC_IP[15:0];
      4'd8:    hw = DST_IP[31:16];
      4'd9:    hw = DST_IP[15:0];
      default: hw = 16'h0000;
    endcase
  end

  assign hdr = {DST_MAC, SRC_MAC, 16'h0800,
                16'h4500, total_len, ip_id_q, 16'h0000, TTL, 8'h11, csum_q, SRC_IP, DST_IP,
                SRC_PORT, port_q, udp_len, 16'h0000};

  always_comb begin
    for (int i = 0; i < 42; i++) begin
      hdr_b[i] = hdr[335-8*i -: 8];
    end
  end

  // Each lane picks a header byte, an incrementing payload byte, or zero padding.
  always_comb begin
    word_data = '0;
    for (int l = 0; l < 4; l++) begin
      lane_idx[l] = {word_idx_q, 2'b00} + 11'(l);
      if (lane_idx[l] < 11'd42) begin
        word_data[31-8*l -: 8] = hdr_b[lane_idx[l][5:0]];
      end else if (lane_idx[l] < frame_len) begin
        word_data[31-8*l -: 8] = lane_idx[l][7:0] - 8'd42;
      end
    end
  end

  assign word_sof  = (word_idx_q == 9'd0);
  assign word_eof  = (word_idx_q == last_word);
  assign next_word = {(word_eof ? frame_len[1:0] : 2'b00), word_eof, word_sof, word_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StCsum;
      StCsum:  if (hw_idx_q == 4'd9) state_d = StFold;
      StFold:  state_d = StSend;
      StSend:  if (eof_xfer) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q       <= '0;
      port_q      <= '0;
      ip_id_q     <= '0;
      csum_q      <= '0;
      pkt_count_q <= '0;
      sum_q       <= '0;
      hw_idx_q    <= '0;
      word_idx_q  <= '0;
      data_q      <= '0;
      src_rdy_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= eof_xfer;
      err_q  <= start && (state_q == StIdle) && !len_ok;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            len_q    <= payload_len;
            port_q   <= dst_port;
            sum_q    <= '0;
            hw_idx_q <= '0;
          end
        end
        StCsum: begin
          sum_q    <= sum_q + {4'b0, hw};
          hw_idx_q <= hw_idx_q + 4'd1;
        end
        StFold: begin
          csum_q     <= ~fold2;
          word_idx_q <= '0;
        end
        StSend: begin
          if (!src_rdy_q) begin
            data_q     <= next_word;
            src_rdy_q  <= 1'b1;
            word_idx_q <= word_idx_q + 9'd1;
          end else if (xfer) begin
            if (data_q[33]) begin
              data_q      <= '0;
              src_rdy_q   <= 1'b0;
              ip_id_q     <= ip_id_q + 16'd1;
              pkt_count_q <= pkt_count_q + 16'd1;
            end else begin
              data_q     <= next_word;
              word_idx_q <= word_idx_q + 9'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign done           = done_q;
  assign err            = err_q;
  assign pkt_count      = pkt_count_q;
  assign tx_f36_data    = data_q;
  assign tx_f36_src_rdy = src_rdy_q;

endmodule

// File: tb/tb_udp_tx_framer.sv
// Randomized bench for udp_tx_framer: a byte-level frame model predicts every
// word, with throttled sink, back-to-back, illegal-length and reset cases.
module tb_udp_tx_framer;

  localparam logic [47:0] DST_MAC  = 48'h0023_DFFF_3311;
  localparam logic [47:0] SRC_MAC  = 48'h0037_FFFF_3737;
  localparam logic [31:0] SRC_IP   = 32'hA9FE_4D01;
  localparam logic [31:0] DST_IP   = 32'hA9FE_4D9D;
  localparam logic [15:0] SRC_PORT = 16'h1234;
  localparam logic [7:0]  TTL      = 8'h40;

  logic        clk = 1'b0;
  logic        rst, start, tx_f36_dst_rdy;
  logic [10:0] payload_len;
  logic [15:0] dst_port;
  logic        busy, done, err, tx_f36_src_rdy;
  logic [15:0] pkt_count;
  logic [35:0] tx_f36_data;

  udp_tx_framer dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .payload_len    (payload_len),
    .dst_port       (dst_port),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .pkt_count      (pkt_count),
    .tx_f36_data    (tx_f36_data),
    .tx_f36_src_rdy (tx_f36_src_rdy),
    .tx_f36_dst_rdy (tx_f36_dst_rdy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_id;
  logic [15:0] exp_pkt;

  logic [7:0]  fb    [0:1599];
  logic [35:0] exp_w [0:399];
  int          exp_nw;
  logic [35:0] got_q [$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference frame: list of header fields in wire order, then payload bytes.
  task automatic build_expect(input int len, input logic [15:0] port, input logic [15:0] id);
    int t, p, s;
    int hw [10];
    logic [15:0] cs;
    logic [47:0] fv [15];
    int fn [15];
    logic [47:0] tmp;
    logic [1:0]  occ;
    bit eof;
    t = 42 + len;
    for (int i = 0; i < 1600; i++) fb[i] = 8'h00;
    hw = '{32'h4500, 28 + len, int'(id), 0, int'({TTL, 8'h11}), 0,
           int'(SRC_IP[31:16]), int'(SRC_IP[15:0]), int'(DST_IP[31:16]), int'(DST_IP[15:0])};
    s = 0;
    for (int i = 0; i < 10; i++) s += hw[i];
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    cs = ~s[15:0];
    fv = '{DST_MAC, SRC_MAC, 48'h0800, 48'h4500, 48'(28 + len), 48'(id), 48'h0,
           48'({TTL, 8'h11}), 48'(cs), 48'(SRC_IP), 48'(DST_IP), 48'(SRC_PORT), 48'(port),
           48'(8 + len), 48'h0};
    fn = '{6, 6, 2, 2, 2, 2, 2, 2, 2, 4, 4, 2, 2, 2, 2};
    p = 0;
    for (int f = 0; f < 15; f++) begin
      for (int b = 0; b < fn[f]; b++) begin
        tmp = fv[f] >> (8 * (fn[f] - 1 - b));
        fb[p] = tmp[7:0];
        p++;
      end
    end
    for (int k = 0; k < len; k++) fb[42+k] = 8'(k);
    exp_nw = (t + 3) / 4;
    for (int w = 0; w < exp_nw; w++) begin
      eof = (w == exp_nw - 1);
      occ = eof ? 2'(t % 4) : 2'd0;
      exp_w[w] = {occ, eof, (w == 0), fb[4*w], fb[4*w+1], fb[4*w+2], fb[4*w+3]};
    end
  endtask

  task automatic issue_start(input int len, input logic [15:0] port);
    payload_len = 11'(len);
    dst_port    = port;
    start       = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Entered #1 after the accepting edge; returns #1 after the EOF edge (done cycle),
  // or right after asserting reset when abort_at words have moved.
  task automatic collect(input int len, input logic [15:0] port, input int duty,
                         input bit inject, input int abort_at);
    int n, guard, stall_bad, drop, busy_bad, err_seen;
    bit held_v, fin;
    logic [35:0] held;
    stall_bad = 0; drop = 0; busy_bad = 0; err_seen = 0;
    held_v = 0; fin = 0; held = '0;
    got_q.delete();
    build_expect(len, port, exp_id);
    n = 0;
    while (!tx_f36_src_rdy && n < 40) begin
      @(posedge clk);
      #1 n++;
      if (!busy) busy_bad++;
      if (err) err_seen++;
      if (inject && n == 3) begin start = 1'b1; payload_len = 11'd0; end
      if (inject && n == 4) start = 1'b0;
    end
    check_val("first_word_latency", n, 12);
    guard = 0;
    while (guard < 20000) begin
      guard++;
      if (abort_at > 0 && got_q.size() == abort_at) begin
        rst = 1'b1;
        #1;
        check_val("rst_src_rdy", tx_f36_src_rdy, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_data", tx_f36_data, 0);
        return;
      end
      if (!tx_f36_src_rdy) drop++;
      if (held_v && tx_f36_data !== held) stall_bad++;
      if (err) err_seen++;
      if (!busy) busy_bad++;
      tx_f36_dst_rdy = ($urandom_range(99) < duty);
      held_v = tx_f36_src_rdy && !tx_f36_dst_rdy;
      held   = tx_f36_data;
      if (tx_f36_src_rdy && tx_f36_dst_rdy) begin
        got_q.push_back(tx_f36_data);
        if (tx_f36_data[33]) begin
          @(posedge clk);
          #1 fin = 1;
          break;
        end
      end
      @(posedge clk);
      #1;
    end
    exp_id++;
    exp_pkt++;
    check_val("frame_finished", fin, 1);
    check_val("end_src_rdy", tx_f36_src_rdy, 0);
    check_val("end_busy", busy, 0);
    check_val("end_done", done, 1);
    check_val("pkt_count", pkt_count, exp_pkt);
    check_val("word_count", got_q.size(), exp_nw);
    for (int w = 0; w < got_q.size() && w < exp_nw; w++)
      check_val($sformatf("L%0d_word%0d", len, w), got_q[w], exp_w[w]);
    check_val("stall_hold", stall_bad, 0);
    check_val("src_rdy_drop", drop, 0);
    check_val("busy_low_mid_frame", busy_bad, 0);
    check_val("err_mid_frame", err_seen, 0);
  endtask

  task automatic bad_start(input int len);
    issue_start(len, 16'hBEEF);
    check_val($sformatf("err_L%0d", len), err, 1);
    check_val($sformatf("err_busy_L%0d", len), busy, 0);
    check_val($sformatf("err_src_rdy_L%0d", len), tx_f36_src_rdy, 0);
    @(posedge clk);
    #1;
    check_val($sformatf("err_pulse_L%0d", len), err, 0);
    check_val($sformatf("err_stay_idle_L%0d", len), busy, 0);
  endtask

  initial begin
    logic [15:0] p;
    int la, lb;
    rst = 1'b1; start = 1'b0; tx_f36_dst_rdy = 1'b0; payload_len = '0; dst_port = '0;
    exp_id = '0; exp_pkt = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_busy", busy, 0);
    check_val("reset_done", done, 0);
    check_val("reset_err", err, 0);
    check_val("reset_pkt_count", pkt_count, 0);
    check_val("reset_data", tx_f36_data, 0);
    check_val("reset_src_rdy", tx_f36_src_rdy, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue_start(18, 16'h0001);
    collect(18, 16'h0001, 100, 1, 0);
    check_val("t1_word0", got_q[0], 36'h10023DFFF);
    check_val("t1_word4", got_q[4], 36'h0002E0000);
    check_val("t1_word6", got_q[6], 36'h08C24A9FE);
    check_val("t1_word14_flags", got_q[14][35:32], 4'b0010);
    @(posedge clk);
    #1 check_val("done_one_cycle", done, 0);

    issue_start(1, 16'h5555);
    collect(1, 16'h5555, 100, 0, 0);
    check_val("t2_last_word", got_q[10], 36'hE00000000);
    check_val("t2_total_len", got_q[4][31:16], 16'h001D);

    bad_start(0);
    bad_start(1473);

    p = 16'($urandom);
    issue_start(1472, p);
    collect(1472, p, 50, 0, 0);
    check_val("t3_words", got_q.size(), 379);
    check_val("t3_last_flags", got_q[378][35:32], 4'b1010);

    la = $urandom_range(1, 200);
    lb = $urandom_range(1, 200);
    issue_start(la, 16'h00AA);
    collect(la, 16'h00AA, 100, 0, 0);
    issue_start(lb, 16'h00BB);
    collect(lb, 16'h00BB, 70, 0, 0);

    for (int r = 0; r < 3; r++) begin
      la = $urandom_range(1, 300);
      p  = 16'($urandom);
      issue_start(la, p);
      collect(la, p, $urandom_range(30, 100), 0, 0);
    end

    issue_start(40, 16'h0007);
    collect(40, 16'h0007, 100, 0, 5);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_id  = '0;
    exp_pkt = '0;
    check_val("post_rst_pkt_count", pkt_count, 0);
    issue_start(18, 16'h0001);
    collect(18, 16'h0001, 100, 0, 0);
    check_val("post_rst_csum_word", got_q[6], 36'h08C24A9FE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
